// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Direction encoding and the load-value clamp live here so every counter variant agrees.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Loads outside the count range settle on the top value instead of aliasing.
   function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                              input logic [31:0] modulus);
      return (value >= modulus) ? (modulus - 32'd1) : value;
   endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-count and boundary detection for the modulus up/down counter.
// SATURATE selects hold-at-boundary instead of wrap-around.
module counter_next_value
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 2**WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   output logic [WIDTH-1:0] next_count,
   output logic             boundary
);

   // One extra bit keeps MODULUS = 2**WIDTH representable and avoids relying on overflow.
   localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

   logic [WIDTH:0] count_ext;

   assign count_ext = {1'b0, count};

   always_comb begin
      next_count = count;
      boundary   = 1'b0;
      if (up == DIR_UP) begin
         if (count_ext == TOP) begin
            boundary   = 1'b1;
            next_count = SATURATE ? count : '0;
         end else begin
            next_count = WIDTH'(count_ext + ONE);
         end
      end else begin
         if (count_ext == '0) begin
            boundary   = 1'b1;
            next_count = SATURATE ? count : WIDTH'(TOP);
         end else begin
            next_count = WIDTH'(count_ext - ONE);
         end
      end
   end

endmodule

// File: rtl/counter_nbit_updown.sv
// Parametrised modulus up/down counter with parallel load, terminal count and wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the boundaries instead of wrapping.
module counter_nbit_updown
   import counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 2**WIDTH,
   parameter int RESET_VALUE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped
);

`ifdef COUNTER_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   logic [WIDTH-1:0] count_q;
   logic             wrapped_q;
   logic [WIDTH-1:0] next_count;
   logic             boundary;

   counter_next_value #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .count      (count_q),
      .up         (up),
      .next_count (next_count),
      .boundary   (boundary)
   );

   // Priority: reset, then load, then enabled step, else hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= WIDTH'(RESET_VALUE);
         wrapped_q <= 1'b0;
      end else if (load) begin
         count_q   <= WIDTH'(clamp_load(32'(load_value), 32'(MODULUS)));
         wrapped_q <= 1'b0;
      end else if (enable) begin
         count_q   <= next_count;
         wrapped_q <= boundary;
      end else begin
         wrapped_q <= 1'b0;
      end
   end

   assign count   = count_q;
   assign wrapped = wrapped_q;
   assign tc      = enable & boundary;

endmodule

// File: tb/tb_counter_nbit_updown.sv
// Scoreboard bench for counter_nbit_updown: directed test-plan sequences then random traffic.
// Honours COUNTER_SATURATE_EN so the reference model matches the build under test.
module tb_counter_nbit_updown;

   localparam int WIDTH       = 4;
   localparam int MODULUS     = 10;
   localparam int RESET_VALUE = 0;

`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset, enable, up, load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             tc, wrapped;

   counter_nbit_updown #(
      .WIDTH       (WIDTH),
      .MODULUS     (MODULUS),
      .RESET_VALUE (RESET_VALUE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .tc         (tc),
      .wrapped    (wrapped)
   );

   always #5 clock = ~clock;

   typedef struct {
      int tag;
      int cnt;
      bit wr;
      bit tc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_cnt;
   bit   m_wr;
   int   tag = 0;

   // Reference model: counting on the integers modulo MODULUS.
   task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
      exp_t x;
      int   sel;
      bit   crossing;
      reset      = r;
      enable     = e;
      up         = u;
      load       = l;
      sel        = lv;
      load_value = sel[WIDTH-1:0];
      x.tag = tag;
      x.cnt = m_cnt;
      x.wr  = m_wr;
      x.tc  = e && (u ? (m_cnt == MODULUS - 1) : (m_cnt == 0));
      sb.push_back(x);
      tag++;
      if (r) begin
         m_cnt = RESET_VALUE;
         m_wr  = 1'b0;
      end else if (l) begin
         m_cnt = (lv >= MODULUS) ? MODULUS - 1 : lv;
         m_wr  = 1'b0;
      end else if (e) begin
         crossing = u ? (m_cnt + 1 == MODULUS) : (m_cnt == 0);
         if (!(crossing && SAT))
            m_cnt = (m_cnt + (u ? 1 : MODULUS - 1)) % MODULUS;
         m_wr = crossing;
      end else begin
         m_wr = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: compares every presented cycle against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (int'(count) != x.cnt) begin
               errors++;
               $display("FAIL count step %0d: got %0d expected %0d", x.tag, count, x.cnt);
            end
            checks++;
            if (wrapped !== x.wr) begin
               errors++;
               $display("FAIL wrapped step %0d: got %b expected %b", x.tag, wrapped, x.wr);
            end
            checks++;
            if (tc !== x.tc) begin
               errors++;
               $display("FAIL tc step %0d: got %b expected %b", x.tag, tc, x.tc);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      up         = 1'b0;
      load       = 1'b0;
      load_value = '0;
      @(posedge clock);
      #1;
      m_cnt = RESET_VALUE;
      m_wr  = 1'b0;

      // Count up through the wrap point.
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
      // Load 3, count down through zero.
      step(0, 0, 0, 1, 3);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      // Out-of-range load clamps and beats enable.
      step(0, 1, 1, 1, 12);
      step(0, 0, 1, 0, 0);
      // Enable toggling from 8 upward.
      step(0, 0, 1, 1, 8);
      for (int i = 0; i < 6; i++) step(0, (i % 2) == 0, 1, 0, 0);
      // Reset beats load and enable.
      step(0, 0, 0, 1, 7);
      step(1, 1, 1, 1, 5);
      step(0, 0, 0, 0, 0);
      // Saturation/wrap pressure at both ends.
      step(0, 0, 1, 1, 8);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      for (int i = 0; i < 800; i++) begin
         bit r, e, u, l;
         int lv;
         r  = ($urandom % 40) == 0;
         l  = ($urandom % 8) == 0;
         e  = ($urandom % 4) != 0;
         u  = ($urandom % 2) == 1;
         lv = (($urandom % 3) == 0) ? (($urandom % 2) ? 0 : MODULUS - 1) : int'($urandom % 16);
         step(r, e, u, l, lv);
      end
      step(0, 0, 0, 0, 0);

      for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clock);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
